vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA timing generator. Samples incoming active-low hsync/vsync at the dot rate (qualified by pix_en), measures line/frame timing, checks it against the 640x480 parameter set and reconstructs pixel coordinates (x_val/y_val) and an active-video flag. Used to validate generator output on-chip and to drive pixel consumers from an external sync source.

Parameters:
H_TOTAL, 800, expected samples per line (hsync fall to hsync fall)
H_SYNC, 96, expected hsync low width in samples
H_BACK, 48, back porch in samples
H_VISIBLE, 640, visible pixels per line
V_TOTAL, 525, expected lines per frame
V_SYNC, 2, expected vsync low width in lines
V_BACK, 33, back porch in lines
V_VISIBLE, 480, visible lines per frame
LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)

Ports:
board_clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
pix_en  in  1  sample strobe, one per dot clock; all state advances only when high
hsync_in  in  1  horizontal sync, active low
vsync_in  in  1  vertical sync, active low
x_val  out  10  reconstructed column 0..639; 640 = outside visible area
y_val  out  10  reconstructed row 0..479; 480 = outside visible area
active  out  1  locked and x_val<640 and y_val<480
line_start  out  1  one-cycle pulse on hsync falling-edge sample
frame_start  out  1  one-cycle pulse on first line of frame (v index 0)
locked  out  1  timing matches parameters for LOCK_FRAMES frames
sync_err  out  1  one-cycle pulse on any timing mismatch or timeout
h_meas  out  12  last measured line length in samples
v_meas  out  12  last measured frame length in lines

Behaviour:
- Reset: x_val=640, y_val=480, active=0, line_start=0, frame_start=0, locked=0, sync_err=0, h_meas=0, v_meas=0; hs_q=vs_q=1, all counters 0, "seen_line"/"seen_frame" flags 0.
- Cycles with pix_en=0: no state change; pulse outputs forced 0.
- Edge detect per sample: hfall = hs_q & ~hsync_in; hrise = ~hs_q & hsync_in; same for vsync; hs_q/vs_q updated each sample.
- Horizontal index: h_idx = hfall ? 0 : min(h_cnt+1, 4095); h_cnt <= h_idx. Sample with hfall is column-index 0.
- On hfall: if seen_line, h_meas <= h_cnt+1 (12-bit saturating); seen_line <= 1. Line mismatch (h_meas value != H_TOTAL) -> line_bad.
- hsync low width counted in samples; captured on hrise; != H_SYNC -> line_bad.
- vsync fall sets vs_pend. Vertical index advances on hfall: v_idx = (vs_pend or vfall this sample) ? 0 : min(v_cnt+1,4095); pend cleared. Coincident vfall+hfall -> that line is row-index 0.
- On v reset: if seen_frame, v_meas <= v_cnt+1; frame_start pulses. vsync low width counted in lines (hfall samples while vsync low, including the falling line); checked at vsync rise against V_SYNC.
- Coordinates registered, latency 1 clock from sample: x = h_idx-(H_SYNC+H_BACK) if that 12-bit difference (unsigned wrap) < H_VISIBLE else 640; y likewise with V_SYNC+V_BACK, V_VISIBLE, 480.
- Lock FSM states: SEARCH, TRACK, LOCKED. SEARCH->TRACK on first frame_start. In TRACK, each frame_start with v_meas==V_TOTAL and no line_bad/vsync mismatch since prior frame_start increments good_cnt; good_cnt==LOCK_FRAMES -> LOCKED (locked=1). Any mismatch in TRACK/LOCKED: sync_err pulse, good_cnt=0, locked=0, state TRACK.
- Timeout: h_cnt reaching 4095 -> sync_err pulse (once), state SEARCH, locked=0, seen_line=seen_frame=0.
- Reset mid-frame: everything returns to reset values the next clock regardless of pix_en.
- Measurements are not gated by lock; first h_meas after reset/timeout needs two hsync falls.

Test Plan:
- Ideal 800x525 sync stream, pix_en=1 -> h_meas=800, v_meas=525, locked rises at the 3rd frame_start (2 good full frames), no sync_err.
- Locked stream, sample 144 of line 35 -> next clock x_val=0, y_val=0, active=1; sample 143 -> x_val=640, active=0; line 515 -> y_val=480.
- One line of 801 samples while locked -> sync_err pulse at next hfall, locked=0; relocks after 2 further good frames.
- hsync held high 4096 samples -> single sync_err, state SEARCH, locked=0; sync restored -> locks after 1+2 frames.
- pix_en toggling 1/0 with same sample stream -> identical h_meas/v_meas/lock timing in sample count; outputs frozen on pix_en=0 cycles.
- reset asserted mid-line while locked -> next clock all outputs at reset values; vsync fall coincident with hfall afterwards -> that line y index 0, frame_start pulses.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: measures hsync/vsync timing, checks it against the
// configured mode, reconstructs pixel coordinates and tracks lock over whole frames.
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        board_clock,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  x_val,
    output logic [9:0]  y_val,
    output logic        active,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [11:0] h_meas,
    output logic [11:0] v_meas
);
    localparam logic [11:0] HT   = 12'(H_TOTAL);
    localparam logic [11:0] HSW  = 12'(H_SYNC);
    localparam logic [11:0] HOFS = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] HV   = 12'(H_VISIBLE);
    localparam logic [11:0] VT   = 12'(V_TOTAL);
    localparam logic [11:0] VSW  = 12'(V_SYNC);
    localparam logic [11:0] VOFS = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] VV   = 12'(V_VISIBLE);
    localparam logic [3:0]  LF   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    state_t      state_q, state_d;
    logic        hs_q, vs_q, vs_pend_q, vs_pend_d;
    logic        seen_line_q, seen_line_d, seen_frame_q, seen_frame_d, bad_q, bad_d;
    logic [11:0] h_cnt_q, v_cnt_q, hlow_q, hlow_d, vlow_q, vlow_d;
    logic [11:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
    logic [3:0]  good_q, good_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        active_q, active_d, lstart_q, fstart_q, locked_q, locked_d, err_q, err_d;

    logic        hfall, hrise, vfall, vrise, v_rst, timeout, mis, x_in, y_in;
    logic [11:0] h_inc, h_idx, v_inc, v_idx, hx, vy;

    always_comb begin
        hfall   = hs_q & ~hsync_in;
        hrise   = ~hs_q & hsync_in;
        vfall   = vs_q & ~vsync_in;
        vrise   = ~vs_q & vsync_in;
        h_inc   = sat_inc(h_cnt_q);
        h_idx   = hfall ? 12'd0 : h_inc;
        v_inc   = sat_inc(v_cnt_q);
        // A pending or coincident vsync fall makes this hsync line row 0.
        v_rst   = hfall & (vs_pend_q | vfall);
        v_idx   = !hfall ? v_cnt_q : (v_rst ? 12'd0 : v_inc);
        timeout = (h_idx == 12'hFFF) && (h_cnt_q != 12'hFFF);

        mis = (hfall & seen_line_q & (h_inc != HT))
            | (hrise & (hlow_q != HSW))
            | (vrise & (vlow_q != VSW))
            | (v_rst & seen_frame_q & (v_inc != VT));

        seen_line_d  = seen_line_q | hfall;
        seen_frame_d = seen_frame_q | v_rst;
        h_meas_d     = (hfall & seen_line_q) ? h_inc : h_meas_q;
        v_meas_d     = (v_rst & seen_frame_q) ? v_inc : v_meas_q;
        hlow_d       = hfall ? 12'd1 : (!hsync_in ? sat_inc(hlow_q) : hlow_q);
        vlow_d       = vfall ? 12'd1 : ((hfall & ~vsync_in) ? sat_inc(vlow_q) : vlow_q);
        vs_pend_d    = hfall ? 1'b0 : (vs_pend_q | vfall);
        bad_d        = v_rst ? 1'b0 : (bad_q | mis);

        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        if (timeout) begin
            err_d        = 1'b1;
            state_d      = SEARCH;
            good_d       = 4'd0;
            seen_line_d  = 1'b0;
            seen_frame_d = 1'b0;
        end else begin
            case (state_q)
                SEARCH: if (v_rst) begin
                    state_d = TRACK;
                    good_d  = 4'd0;
                end
                TRACK, LOCKED: begin
                    if (mis) begin
                        err_d   = 1'b1;
                        good_d  = 4'd0;
                        state_d = TRACK;
                    end else if (v_rst && !bad_q && state_q == TRACK) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LF) state_d = LOCKED;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        locked_d = (state_d == LOCKED);

        hx       = h_idx - HOFS;
        vy       = v_idx - VOFS;
        x_in     = hx < HV;
        y_in     = vy < VV;
        x_d      = x_in ? hx[9:0] : 10'd640;
        y_d      = y_in ? vy[9:0] : 10'd480;
        active_d = locked_d & x_in & y_in;
    end

    always_ff @(posedge board_clock) begin
        if (reset) begin
            state_q      <= SEARCH;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            vs_pend_q    <= 1'b0;
            seen_line_q  <= 1'b0;
            seen_frame_q <= 1'b0;
            bad_q        <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            hlow_q       <= '0;
            vlow_q       <= '0;
            h_meas_q     <= '0;
            v_meas_q     <= '0;
            good_q       <= '0;
            x_q          <= 10'd640;
            y_q          <= 10'd480;
            active_q     <= 1'b0;
            lstart_q     <= 1'b0;
            fstart_q     <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else if (pix_en) begin
            state_q      <= state_d;
            hs_q         <= hsync_in;
            vs_q         <= vsync_in;
            vs_pend_q    <= vs_pend_d;
            seen_line_q  <= seen_line_d;
            seen_frame_q <= seen_frame_d;
            bad_q        <= bad_d;
            h_cnt_q      <= h_idx;
            v_cnt_q      <= v_idx;
            hlow_q       <= hlow_d;
            vlow_q       <= vlow_d;
            h_meas_q     <= h_meas_d;
            v_meas_q     <= v_meas_d;
            good_q       <= good_d;
            x_q          <= x_d;
            y_q          <= y_d;
            active_q     <= active_d;
            lstart_q     <= hfall;
            fstart_q     <= v_rst;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end else begin
            lstart_q <= 1'b0;
            fstart_q <= 1'b0;
            err_q    <= 1'b0;
        end
    end

    assign x_val       = x_q;
    assign y_val       = y_q;
    assign active      = active_q;
    assign line_start  = lstart_q;
    assign frame_start = fstart_q;
    assign locked      = locked_q;
    assign sync_err    = err_q;
    assign h_meas      = h_meas_q;
    assign v_meas      = v_meas_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 40x20 timing set so
// that several complete frames fit in a short run.
module tb_vga_sync_decoder;
    localparam int HT = 40, HS = 6, HB = 4, HV = 24;
    localparam int VT = 20, VS = 2, VB = 3, VV = 12;

    logic        clk = 1'b0, rst, en, hs, vs;
    logic [9:0]  x_val, y_val;
    logic        active, line_start, frame_start, locked, sync_err;
    logic [11:0] h_meas, v_meas;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV), .LOCK_FRAMES(2)
    ) dut (
        .board_clock(clk), .reset(rst), .pix_en(en), .hsync_in(hs), .vsync_in(vs),
        .x_val(x_val), .y_val(y_val), .active(active), .line_start(line_start),
        .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
        .h_meas(h_meas), .v_meas(v_meas)
    );

    always #5 clk = ~clk;

    int   n_chk = 0, n_err = 0;
    int   fs_cnt, se_cnt, lock_at, frz_bad, base;
    logic lk_prev;
    bit   gap;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic observe();
        if (frame_start) fs_cnt++;
        if (sync_err) se_cnt++;
        if (locked && !lk_prev) lock_at = fs_cnt;
        lk_prev = locked;
    endtask

    // One real sample; in gap mode it is followed by a pix_en=0 cycle carrying
    // inverted sync levels, which must leave every output untouched.
    task automatic send(input logic h, input logic v);
        logic [9:0]  sx, sy;
        logic [11:0] shm, svm;
        logic        sa, sl;
        en = 1'b1; hs = h; vs = v;
        @(posedge clk); #1;
        observe();
        if (gap) begin
            sx = x_val; sy = y_val; shm = h_meas; svm = v_meas; sa = active; sl = locked;
            en = 1'b0; hs = ~h; vs = ~v;
            @(posedge clk); #1;
            if (x_val !== sx || y_val !== sy || h_meas !== shm || v_meas !== svm ||
                active !== sa || locked !== sl || line_start !== 1'b0 ||
                frame_start !== 1'b0 || sync_err !== 1'b0) frz_bad++;
        end
    endtask

    task automatic do_reset(input logic e);
        rst = 1'b1; en = e; hs = 1'b1; vs = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_x", int'(x_val), 640);
        chk("rst_y", int'(y_val), 480);
        chk("rst_active", int'(active), 0);
        chk("rst_line_start", int'(line_start), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        chk("rst_h_meas", int'(h_meas), 0);
        chk("rst_v_meas", int'(v_meas), 0);
        fs_cnt = 0; se_cnt = 0; lock_at = -1; frz_bad = 0; lk_prev = 1'b0;
    endtask

    // mode 1: coordinate checks on a locked frame; mode 2: first frame after reset
    task automatic run_frame(input int bad_line, input int mode);
        for (int l = 0; l < VT; l++) begin
            for (int p = 0; p < ((l == bad_line) ? HT + 1 : HT); p++) begin
                send(p >= HS, l >= VS);
                if (mode == 1) begin
                    if (l == 5 && p == 9) begin
                        chk("pre_vis_x", int'(x_val), 640);
                        chk("pre_vis_active", int'(active), 0);
                    end
                    if (l == 5 && p == 10) begin
                        chk("origin_x", int'(x_val), 0);
                        chk("origin_y", int'(y_val), 0);
                        chk("origin_active", int'(active), 1);
                    end
                    if (l == 16 && p == 33) begin
                        chk("last_x", int'(x_val), 23);
                        chk("last_y", int'(y_val), 11);
                        chk("last_active", int'(active), 1);
                    end
                    if (l == 16 && p == 34) begin
                        chk("post_x", int'(x_val), 640);
                        chk("post_active", int'(active), 0);
                    end
                    if (l == 17 && p == 10) begin
                        chk("below_y", int'(y_val), 480);
                        chk("below_active", int'(active), 0);
                    end
                end
                if (mode == 2) begin
                    if (l == 0 && p == 0) begin
                        chk("fs_after_rst", int'(frame_start), 1);
                        chk("ls_after_rst", int'(line_start), 1);
                        chk("row0_y", int'(y_val), 480);
                    end
                    if (l == 0 && p == 5) chk("first_hmeas", int'(h_meas), 0);
                    if (l == 1 && p == 5) chk("second_hmeas", int'(h_meas), HT);
                    if (l == 5 && p == 10) begin
                        chk("unlk_x", int'(x_val), 0);
                        chk("unlk_y", int'(y_val), 0);
                        chk("unlk_active", int'(active), 0);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; hs = 1'b1; vs = 1'b1; gap = 1'b0;
        do_reset(1'b1);

        // ideal stream: lock at the third frame_start
        for (int f = 0; f < 3; f++) run_frame(-1, (f == 2) ? 1 : 0);
        chk("lock_at", lock_at, 3);
        chk("locked", int'(locked), 1);
        chk("h_meas", int'(h_meas), HT);
        chk("v_meas", int'(v_meas), VT);
        chk("no_err", se_cnt, 0);

        // one long line while locked
        run_frame(7, 0);
        chk("long_line_err", se_cnt, 1);
        chk("long_line_unlock", int'(locked), 0);
        for (int f = 0; f < 3; f++) run_frame(-1, 0);
        chk("relock_at", lock_at, 7);
        chk("relock", int'(locked), 1);
        chk("relock_err", se_cnt, 1);

        // hsync stuck high past the timeout
        repeat (4200) send(1'b1, 1'b1);
        chk("timeout_err", se_cnt, 2);
        chk("timeout_unlock", int'(locked), 0);
        chk("timeout_hmeas", int'(h_meas), HT);
        base = fs_cnt;
        for (int f = 0; f < 3; f++) run_frame(-1, 0);
        chk("timeout_relock_at", lock_at, base + 3);
        chk("timeout_relock", int'(locked), 1);
        chk("timeout_relock_err", se_cnt, 2);

        // same stream with pix_en toggling
        do_reset(1'b1);
        gap = 1'b1;
        for (int f = 0; f < 3; f++) run_frame(-1, 0);
        gap = 1'b0;
        chk("gap_lock_at", lock_at, 3);
        chk("gap_h_meas", int'(h_meas), HT);
        chk("gap_v_meas", int'(v_meas), VT);
        chk("gap_err", se_cnt, 0);
        chk("gap_frozen", frz_bad, 0);

        // reset mid-line while locked, then restart on a coincident h/v fall
        for (int l = 0; l < 3; l++)
            for (int p = 0; p < HT; p++) send(p >= HS, l >= VS);
        for (int p = 0; p < 15; p++) send(p >= HS, 1'b1);
        chk("pre_rst_locked", int'(locked), 1);
        do_reset(1'b0);
        run_frame(-1, 2);
        chk("post_rst_fs", fs_cnt, 1);
        chk("post_rst_locked", int'(locked), 0);
        chk("post_rst_err", se_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
